// File: rtl/dm_cache_ctrl_fsm.sv
// Direct-mapped, write-back, write-allocate cache controller.
// Sequences an external tag store and line-wide data store (both with a
// synchronous 1-cycle read) between a 32-bit CPU word port and a line memory.
// One request is in flight at a time; misses refill the line and then replay
// the lookup so hits and misses finish through the same COMPARE path.
module dm_cache_ctrl_fsm #(
  parameter int ADDR_WIDTH       = 32,
  parameter int LINE_WIDTH       = 512,
  parameter int CACHE_LINES      = 8,
  parameter int CACHE_LINE_WIDTH = $clog2(CACHE_LINES),
  parameter int OFFSET_WIDTH     = $clog2(LINE_WIDTH / 8),
  parameter int TAG_WIDTH        = ADDR_WIDTH - CACHE_LINE_WIDTH - OFFSET_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cpu_req_valid,
  input  logic                        cpu_req_rw,
  input  logic [ADDR_WIDTH-1:0]       cpu_req_addr,
  input  logic [31:0]                 cpu_req_data,
  output logic                        cpu_req_ready,
  output logic                        cpu_res_valid,
  output logic [31:0]                 cpu_res_data,
  output logic                        mem_req_valid,
  output logic                        mem_req_rw,
  output logic [ADDR_WIDTH-1:0]       mem_req_addr,
  output logic [LINE_WIDTH-1:0]       mem_req_data,
  input  logic                        mem_ready,
  input  logic [LINE_WIDTH-1:0]       mem_rdata,
  output logic [CACHE_LINE_WIDTH-1:0] tag_req_index,
  output logic                        tag_req_we,
  output logic                        tag_write_valid,
  output logic                        tag_write_dirty,
  output logic [TAG_WIDTH-1:0]        tag_write_tag,
  input  logic                        tag_read_valid,
  input  logic                        tag_read_dirty,
  input  logic [TAG_WIDTH-1:0]        tag_read_tag,
  output logic [CACHE_LINE_WIDTH-1:0] data_req_index,
  output logic                        data_req_we,
  output logic [LINE_WIDTH-1:0]       data_write,
  input  logic [LINE_WIDTH-1:0]       data_read
);

  localparam int WORD_SEL_WIDTH = OFFSET_WIDTH - 2;

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_COMPARE     = 3'd1;
  localparam logic [2:0] ST_WRITE_BACK  = 3'd2;
  localparam logic [2:0] ST_ALLOCATE    = 3'd3;
  localparam logic [2:0] ST_REFILL_WAIT = 3'd4;

  logic [2:0]                  state_r;
  logic [2:0]                  state_nxt_s;
  logic                        req_rw_r;
  logic [ADDR_WIDTH-1:0]       req_addr_r;
  logic [31:0]                 req_data_r;
  logic [TAG_WIDTH-1:0]        victim_tag_r;
  logic [LINE_WIDTH-1:0]       victim_line_r;

  logic [TAG_WIDTH-1:0]        req_tag_s;
  logic [CACHE_LINE_WIDTH-1:0] req_index_s;
  logic [WORD_SEL_WIDTH-1:0]   req_word_s;
  logic [CACHE_LINE_WIDTH-1:0] cpu_index_s;
  logic                        hit_s;
  logic                        unused_byte_sel_s;

  // Extract one 32-bit word from a line.
  function automatic logic [31:0] line_word(input logic [LINE_WIDTH-1:0] line,
                                            input logic [WORD_SEL_WIDTH-1:0] sel);
    line_word = line[{sel, 5'd0} +: 32];
  endfunction

  // Replace one 32-bit word inside a line, keeping the others.
  function automatic logic [LINE_WIDTH-1:0] line_merge(input logic [LINE_WIDTH-1:0] line,
                                                       input logic [WORD_SEL_WIDTH-1:0] sel,
                                                       input logic [31:0] word);
    line_merge = line;
    line_merge[{sel, 5'd0} +: 32] = word;
  endfunction

  assign req_tag_s         = req_addr_r[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign req_index_s       = req_addr_r[OFFSET_WIDTH +: CACHE_LINE_WIDTH];
  assign req_word_s        = req_addr_r[2 +: WORD_SEL_WIDTH];
  assign cpu_index_s       = cpu_req_addr[OFFSET_WIDTH +: CACHE_LINE_WIDTH];
  assign hit_s             = tag_read_valid && (tag_read_tag == req_tag_s);
  // Byte-lane bits are latched with the address but never used (word access only).
  assign unused_byte_sel_s = ^req_addr_r[1:0];

  // State register plus request and victim capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      req_rw_r      <= 1'b0;
      req_addr_r    <= {ADDR_WIDTH{1'b0}};
      req_data_r    <= 32'd0;
      victim_tag_r  <= {TAG_WIDTH{1'b0}};
      victim_line_r <= {LINE_WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        ST_IDLE: begin
          if (cpu_req_valid) begin
            req_rw_r   <= cpu_req_rw;
            req_addr_r <= cpu_req_addr;
            req_data_r <= cpu_req_data;
          end
        end
        ST_COMPARE: begin
          if (!hit_s && tag_read_valid && tag_read_dirty) begin
            victim_tag_r  <= tag_read_tag;
            victim_line_r <= data_read;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state and output decode; store indices follow the CPU only in IDLE.
  always_comb begin
    state_nxt_s     = state_r;
    cpu_req_ready   = 1'b0;
    cpu_res_valid   = 1'b0;
    cpu_res_data    = 32'd0;
    mem_req_valid   = 1'b0;
    mem_req_rw      = 1'b0;
    mem_req_addr    = {ADDR_WIDTH{1'b0}};
    mem_req_data    = {LINE_WIDTH{1'b0}};
    tag_req_index   = req_index_s;
    tag_req_we      = 1'b0;
    tag_write_valid = 1'b0;
    tag_write_dirty = 1'b0;
    tag_write_tag   = {TAG_WIDTH{1'b0}};
    data_req_index  = req_index_s;
    data_req_we     = 1'b0;
    data_write      = {LINE_WIDTH{1'b0}};
    case (state_r)
      ST_IDLE: begin
        cpu_req_ready  = 1'b1;
        tag_req_index  = cpu_index_s;
        data_req_index = cpu_index_s;
        if (cpu_req_valid) begin
          state_nxt_s = ST_COMPARE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_COMPARE: begin
        if (hit_s) begin
          cpu_res_valid = 1'b1;
          state_nxt_s   = ST_IDLE;
          if (req_rw_r) begin
            tag_req_we      = 1'b1;
            tag_write_valid = 1'b1;
            tag_write_dirty = 1'b1;
            tag_write_tag   = req_tag_s;
            data_req_we     = 1'b1;
            data_write      = line_merge(data_read, req_word_s, req_data_r);
          end else begin
            cpu_res_data = line_word(data_read, req_word_s);
          end
        end else if (tag_read_valid && tag_read_dirty) begin
          state_nxt_s = ST_WRITE_BACK;
        end else begin
          state_nxt_s = ST_ALLOCATE;
        end
      end
      ST_WRITE_BACK: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_addr  = {victim_tag_r, req_index_s, {OFFSET_WIDTH{1'b0}}};
        mem_req_data  = victim_line_r;
        if (mem_ready) begin
          state_nxt_s = ST_ALLOCATE;
        end else begin
          state_nxt_s = ST_WRITE_BACK;
        end
      end
      ST_ALLOCATE: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b0;
        mem_req_addr  = {req_tag_s, req_index_s, {OFFSET_WIDTH{1'b0}}};
        if (mem_ready) begin
          tag_req_we      = 1'b1;
          tag_write_valid = 1'b1;
          tag_write_dirty = 1'b0;
          tag_write_tag   = req_tag_s;
          data_req_we     = 1'b1;
          data_write      = mem_rdata;
          state_nxt_s     = ST_REFILL_WAIT;
        end else begin
          state_nxt_s = ST_ALLOCATE;
        end
      end
      ST_REFILL_WAIT: begin
        // Re-read the freshly written line so COMPARE sees the new tag.
        state_nxt_s = ST_COMPARE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

endmodule
